// File: rtl/mul_ctrl_pkg.sv
// Shared state encoding, requester IDs and counter sizing for the multiplier
// sequencer and its round-robin arbiter.
package mul_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic REQ_ID_MAIN = 1'b0;
  localparam logic REQ_ID_AUX  = 1'b1;

  localparam int CNT_W = 4;

  // The counter counts down to zero, so a settle of N cycles loads N-1.
  function automatic logic [CNT_W-1:0] settleLoad(input int waitCycles);
    return CNT_W'(waitCycles - 1);
  endfunction

endpackage

// File: rtl/mul_rr_arb2.sv
// Two-port round-robin grant logic; purely combinational, one-hot output.
module mul_rr_arb2
  import mul_ctrl_pkg::*;
(
  input  logic [1:0] i_valid,
  input  logic       i_last_grant,
  input  logic       i_enable,
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant = 2'b00;
    if (i_enable) begin
      if (&i_valid) begin
        // On a tie, serve whichever port was not served last.
        if (i_last_grant == REQ_ID_AUX) begin
          o_grant = 2'b01;
        end else begin
          o_grant = 2'b10;
        end
      end else begin
        o_grant = i_valid;
      end
    end
  end

endmodule

// File: rtl/mul_arbiter_seq.sv
// Arbitrates two requesters onto the shared multiplier, waits for it to settle
// and returns the 64-bit product through a tagged valid/ready response port.
module mul_arbiter_seq
  import mul_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_x,
  input  logic [31:0] req0_y,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_x,
  input  logic [31:0] req1_y,
  output logic [31:0] mul_x,
  output logic [31:0] mul_y,
  input  logic [63:0] mul_product,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_hi,
  output logic [31:0] rsp_lo,
  output logic        busy
);

  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : gBadWait
    $error("mul_arbiter_seq: WAIT_CYCLES must be within 1..15");
  end

  state_t           r_state;
  state_t           w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_last_grant;
  logic [31:0]      r_mul_x;
  logic [31:0]      r_mul_y;
  logic [31:0]      r_rsp_hi;
  logic [31:0]      r_rsp_lo;
  logic             r_rsp_id;
  logic [1:0]       w_grant;
  logic             w_accept;
  logic             w_accept_id;

  mul_rr_arb2 u_arb (
    .i_valid      ({req1_valid, req0_valid}),
    .i_last_grant (r_last_grant),
    .i_enable     (r_state == ST_IDLE),
    .o_grant      (w_grant)
  );

  assign w_accept    = |w_grant;
  assign w_accept_id = w_grant[1] ? REQ_ID_AUX : REQ_ID_MAIN;

  assign req0_ready = w_grant[0];
  assign req1_ready = w_grant[1];
  assign mul_x      = r_mul_x;
  assign mul_y      = r_mul_y;
  assign rsp_hi     = r_rsp_hi;
  assign rsp_lo     = r_rsp_lo;
  assign rsp_id     = r_rsp_id;
  assign rsp_valid  = (r_state == ST_DONE);
  assign busy       = (r_state != ST_IDLE);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept) w_next_state = ST_SETTLE;
      ST_SETTLE: if (r_cnt == '0) w_next_state = ST_DONE;
      ST_DONE:   if (rsp_ready) w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // clear wins over any handshake in the same cycle and abandons the operation.
  always_ff @(posedge clock) begin
    if (clear) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_last_grant <= REQ_ID_AUX;
      r_mul_x      <= '0;
      r_mul_y      <= '0;
      r_rsp_hi     <= '0;
      r_rsp_lo     <= '0;
      r_rsp_id     <= REQ_ID_MAIN;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_mul_x      <= w_grant[1] ? req1_x : req0_x;
        r_mul_y      <= w_grant[1] ? req1_y : req0_y;
        r_rsp_id     <= w_accept_id;
        r_last_grant <= w_accept_id;
        r_cnt        <= settleLoad(WAIT_CYCLES);
      end
      if (r_state == ST_SETTLE) begin
        if (r_cnt != '0) begin
          r_cnt <= r_cnt - CNT_W'(1);
        end else begin
          r_rsp_hi <= mul_product[63:32];
          r_rsp_lo <= mul_product[31:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_mul_arbiter_seq.sv
// Self-checking bench: table vectors, hand sequences for tie/hold/clear corners,
// randomized traffic against a behavioural model, and latency at WAIT 1/2/15.
module tb_mul_arbiter_seq;

  localparam int NDUT = 3;

  function automatic int waitOf(input int d);
    case (d)
      1:       return 1;
      2:       return 15;
      default: return 2;
    endcase
  endfunction

  typedef struct {
    logic        port;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  logic        clock = 1'b0;
  logic        clear;
  logic        r0Valid [NDUT];
  logic        r1Valid [NDUT];
  logic        rspReady[NDUT];
  logic [31:0] r0X[NDUT], r0Y[NDUT], r1X[NDUT], r1Y[NDUT];
  logic        r0Ready[NDUT], r1Ready[NDUT], rspValid[NDUT], rspId[NDUT], busy[NDUT];
  logic [31:0] mulX[NDUT], mulY[NDUT], rspHi[NDUT], rspLo[NDUT];
  logic [63:0] mulP[NDUT];

  int   checks = 0;
  int   failures = 0;
  logic mdlLast = 1'b1;
  logic bothSeen = 1'b0;

  always #5 clock = ~clock;

  for (genvar g = 0; g < NDUT; g++) begin : gDut
    // Stand-in for the ALU's signed multiplier: sign-extend and keep 64 bits.
    assign mulP[g] = {{32{mulX[g][31]}}, mulX[g]} * {{32{mulY[g][31]}}, mulY[g]};

    mul_arbiter_seq #(.WAIT_CYCLES(waitOf(g))) uDut (
      .clock       (clock),
      .clear       (clear),
      .req0_valid  (r0Valid[g]),
      .req0_ready  (r0Ready[g]),
      .req0_x      (r0X[g]),
      .req0_y      (r0Y[g]),
      .req1_valid  (r1Valid[g]),
      .req1_ready  (r1Ready[g]),
      .req1_x      (r1X[g]),
      .req1_y      (r1Y[g]),
      .mul_x       (mulX[g]),
      .mul_y       (mulY[g]),
      .mul_product (mulP[g]),
      .rsp_valid   (rspValid[g]),
      .rsp_ready   (rspReady[g]),
      .rsp_id      (rspId[g]),
      .rsp_hi      (rspHi[g]),
      .rsp_lo      (rspLo[g]),
      .busy        (busy[g])
    );
  end

  always begin
    @(negedge clock);
    #2;
    if (r0Ready[0] && r1Ready[0]) bothSeen = 1'b1;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [63:0] refProd(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 64'(sa * sb);
  endfunction

  function automatic logic [31:0] randOp();
    case ($urandom_range(5))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int d, input logic port, input logic [31:0] x, input logic [31:0] y);
    if (port) begin
      r1Valid[d] = 1'b1; r1X[d] = x; r1Y[d] = y;
    end else begin
      r0Valid[d] = 1'b1; r0X[d] = x; r0Y[d] = y;
    end
  endtask

  task automatic applyReset();
    clear = 1'b1;
    for (int d = 0; d < NDUT; d++) begin
      r0Valid[d] = 1'b0; r1Valid[d] = 1'b0; rspReady[d] = 1'b1;
    end
    repeat (2) @(negedge clock);
    clear = 1'b0;
    mdlLast = 1'b1;
  endtask

  // Called at a negedge with request valids already driven; returns at the
  // negedge after the response handshake.
  task automatic transact(input int d, input logic expPort, input logic [31:0] x,
                          input logic [31:0] y, input int rspDelay);
    int          w;
    int          lat;
    logic        accPort;
    logic        holdOk;
    logic [63:0] prod;
    prod = refProd(x, y);
    #1;
    w = 0;
    while (!(r0Ready[d] || r1Ready[d]) && w < 20) begin
      @(negedge clock); #1; w++;
    end
    if (!(r0Ready[d] || r1Ready[d])) begin
      checkOutput("acceptTimeout", 64'd0, 64'd1);
      r0Valid[d] = 1'b0; r1Valid[d] = 1'b0;
      return;
    end
    checkOutput("grant0", r0Ready[d], expPort == 1'b0);
    checkOutput("grant1", r1Ready[d], expPort == 1'b1);
    accPort = r1Ready[d];
    @(posedge clock);
    if (d == 0) mdlLast = expPort;
    @(negedge clock);
    if (accPort) r1Valid[d] = 1'b0; else r0Valid[d] = 1'b0;
    lat = 1;
    while (!rspValid[d] && lat < 40) begin
      @(negedge clock); lat++;
    end
    if (!rspValid[d]) begin
      checkOutput("rspTimeout", 64'd0, 64'd1);
      return;
    end
    checkOutput("latency", lat, waitOf(d) + 1);
    checkOutput("rspId", rspId[d], expPort);
    checkOutput("rspHi", rspHi[d], prod[63:32]);
    checkOutput("rspLo", rspLo[d], prod[31:0]);
    checkOutput("mulX", mulX[d], x);
    checkOutput("mulY", mulY[d], y);
    checkOutput("readyInDone", {r0Ready[d], r1Ready[d], busy[d]}, 3'b001);
    if (rspDelay > 0) begin
      rspReady[d] = 1'b0;
      holdOk = 1'b1;
      repeat (rspDelay) begin
        @(negedge clock);
        if (!rspValid[d] || rspHi[d] !== prod[63:32] || rspLo[d] !== prod[31:0] ||
            rspId[d] !== expPort || r0Ready[d] || r1Ready[d] || !busy[d]) holdOk = 1'b0;
      end
      checkOutput("holdStable", holdOk, 1'b1);
      rspReady[d] = 1'b1;
    end
    @(negedge clock);
    checkOutput("idleAfterRsp", {busy[d], rspValid[d]}, 2'b00);
  endtask

  vec_t vecs[5];

  initial begin
    logic exp;
    logic noRsp;

    vecs[0] = '{1'b0, 32'd7,         32'd6,         32'h0000_0000, 32'h0000_002A};
    vecs[1] = '{1'b1, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[2] = '{1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[3] = '{1'b0, 32'hFFFF_FFF9, 32'd6,         32'hFFFF_FFFF, 32'hFFFF_FFD6};
    vecs[4] = '{1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001};

    for (int d = 0; d < NDUT; d++) begin
      r0X[d] = '0; r0Y[d] = '0; r1X[d] = '0; r1Y[d] = '0;
    end
    applyReset();
    #1;
    checkOutput("rstMulX", mulX[0], 32'd0);
    checkOutput("rstMulY", mulY[0], 32'd0);
    checkOutput("rstHiLo", {rspHi[0], rspLo[0]}, 64'd0);
    checkOutput("rstIdValidBusy", {rspId[0], rspValid[0], busy[0]}, 3'b000);
    checkOutput("rstReady", {r0Ready[0], r1Ready[0]}, 2'b00);
    @(negedge clock);

    // Both ports contending from reset: grants must alternate starting at 0.
    for (int k = 0; k < 4; k++) begin
      if (!r0Valid[0]) applyStimulus(0, 1'b0, $urandom, $urandom);
      if (!r1Valid[0]) applyStimulus(0, 1'b1, $urandom, $urandom);
      exp = k[0];
      transact(0, exp, exp ? r1X[0] : r0X[0], exp ? r1Y[0] : r0Y[0], 0);
    end
    if (r1Valid[0]) transact(0, 1'b1, r1X[0], r1Y[0], 0);
    if (r0Valid[0]) transact(0, 1'b0, r0X[0], r0Y[0], 0);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, vecs[i].port, vecs[i].x, vecs[i].y);
      transact(0, vecs[i].port, vecs[i].x, vecs[i].y, 0);
      checkOutput($sformatf("vec%0dHi", i), rspHi[0], vecs[i].hi);
      checkOutput($sformatf("vec%0dLo", i), rspLo[0], vecs[i].lo);
      checkOutput($sformatf("vec%0dId", i), rspId[0], vecs[i].port);
    end

    applyStimulus(0, 1'b1, 32'h1234_5678, 32'hFEDC_BA98);
    transact(0, 1'b1, 32'h1234_5678, 32'hFEDC_BA98, 10);

    // Accept on port 0, then clear during SETTLE: nothing may come out.
    applyStimulus(0, 1'b0, 32'd1234, 32'd5678);
    #1;
    checkOutput("clrGrant", r0Ready[0], 1'b1);
    @(posedge clock);
    @(negedge clock);
    r0Valid[0] = 1'b0;
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    mdlLast = 1'b1;
    #1;
    checkOutput("clrMulXY", {mulX[0], mulY[0]}, 64'd0);
    checkOutput("clrHiLo", {rspHi[0], rspLo[0]}, 64'd0);
    checkOutput("clrIdValidBusy", {rspId[0], rspValid[0], busy[0]}, 3'b000);
    noRsp = 1'b1;
    repeat (waitOf(0) + 3) begin
      @(negedge clock);
      if (rspValid[0] || busy[0]) noRsp = 1'b0;
    end
    checkOutput("clrNoRsp", noRsp, 1'b1);
    applyStimulus(0, 1'b0, 32'd99, 32'hFFFF_FFFE);
    applyStimulus(0, 1'b1, 32'd3, 32'd5);
    transact(0, 1'b0, 32'd99, 32'hFFFF_FFFE, 0);
    transact(0, 1'b1, 32'd3, 32'd5, 0);

    // Random traffic; pending requests keep valid high until granted.
    for (int r = 0; r < 40; r++) begin
      if (!r0Valid[0] && $urandom_range(1) == 1) applyStimulus(0, 1'b0, randOp(), randOp());
      if (!r1Valid[0] && $urandom_range(1) == 1) applyStimulus(0, 1'b1, randOp(), randOp());
      if (!r0Valid[0] && !r1Valid[0]) applyStimulus(0, 1'b0, randOp(), randOp());
      exp = (r0Valid[0] && r1Valid[0]) ? ~mdlLast : r1Valid[0];
      transact(0, exp, exp ? r1X[0] : r0X[0], exp ? r1Y[0] : r0Y[0], int'($urandom_range(2)));
    end
    while (r0Valid[0] || r1Valid[0]) begin
      exp = (r0Valid[0] && r1Valid[0]) ? ~mdlLast : r1Valid[0];
      transact(0, exp, exp ? r1X[0] : r0X[0], exp ? r1Y[0] : r0Y[0], 0);
    end

    for (int d = 1; d < NDUT; d++) begin
      applyStimulus(d, 1'b0, 32'hFFFF_FFFD, 32'd11);
      transact(d, 1'b0, 32'hFFFF_FFFD, 32'd11, 0);
    end

    checkOutput("neverBothReady", bothSeen, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
